// File: rtl/multicycle_core.sv
// Multi-cycle RV32I/RV64I integer-subset core (ADD SUB AND OR SLT ADDI LW SW BEQ BNE) with req/ack memories.
// One FSM sequences FETCH/DECODE/EXEC/MEM/WB; any unsupported encoding parks the core in TRAP until reset.
module multicycle_core #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            retire,
  output logic            halt,
  output logic [XLEN-1:0] pc_out
);

  localparam int RIW = $clog2(NREG);
  localparam logic [5:0] NREG6 = 6'(NREG);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n, wb_q, wb_n;
  logic [31:0]     ir;
  logic [XLEN-1:0] rf [NREG];
  logic            pc_ld, ir_ld, wb_ld, rf_we, retire_c;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  logic is_r, is_addi, is_lw, is_sw, is_br, legal, bad_reg;
  assign is_r    = (opcode == 7'b0110011) &&
                   ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010)) ||
                    (f7 == 7'b0100000 && f3 == 3'b000));
  assign is_addi = (opcode == 7'b0010011) && (f3 == 3'b000);
  assign is_lw   = (opcode == 7'b0000011) && (f3 == 3'b010);
  assign is_sw   = (opcode == 7'b0100011) && (f3 == 3'b010);
  assign is_br   = (opcode == 7'b1100011) && (f3[2:1] == 2'b00);
  assign legal   = is_r | is_addi | is_lw | is_sw | is_br;
  // Every legal instruction reads rs1; rs2/rd usage depends on the format.
  assign bad_reg = ({1'b0, rs1} >= NREG6) ||
                   ((is_r | is_sw | is_br) && ({1'b0, rs2} >= NREG6)) ||
                   ((is_r | is_addi | is_lw) && ({1'b0, rd} >= NREG6));

  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  logic [XLEN-1:0] rs1_val, rs2_val, alu_b, alu_res, pc_plus4, br_tgt;
  logic            br_taken;
  assign rs1_val  = rf[rs1[RIW-1:0]];
  assign rs2_val  = rf[rs2[RIW-1:0]];
  assign alu_b    = is_r ? rs2_val : imm_i;
  assign pc_plus4 = pc + XLEN'(4);
  assign br_tgt   = pc + imm_b;
  assign br_taken = f3[0] ? (rs1_val != rs2_val) : (rs1_val == rs2_val);

  always_comb begin
    alu_res = rs1_val + alu_b;
    if (is_r) begin
      case (f3)
        3'b000:  alu_res = f7[5] ? (rs1_val - alu_b) : (rs1_val + alu_b);
        3'b111:  alu_res = rs1_val & alu_b;
        3'b110:  alu_res = rs1_val | alu_b;
        3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(alu_b))};
        default: alu_res = rs1_val + alu_b;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    pc_ld    = 1'b0;
    ir_ld    = 1'b0;
    wb_ld    = 1'b0;
    wb_n     = alu_res;
    rf_we    = 1'b0;
    retire_c = 1'b0;
    case (state)
      S_FETCH: begin
        if (imem_ack) begin
          ir_ld   = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: state_n = (!legal || bad_reg) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (is_br) begin
          // A misaligned taken target faults with the PC still on the branch.
          if (br_taken && br_tgt[1]) begin
            state_n = S_TRAP;
          end else begin
            pc_ld    = 1'b1;
            pc_n     = br_taken ? br_tgt : pc_plus4;
            retire_c = 1'b1;
            state_n  = S_FETCH;
          end
        end else if (is_lw || is_sw) begin
          state_n = S_MEM;
        end else begin
          wb_ld   = 1'b1;
          state_n = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (is_sw) begin
            pc_ld    = 1'b1;
            pc_n     = pc_plus4;
            retire_c = 1'b1;
            state_n  = S_FETCH;
          end else begin
            wb_ld   = 1'b1;
            wb_n    = dmem_rdata;
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        pc_ld    = 1'b1;
        pc_n     = pc_plus4;
        retire_c = 1'b1;
        state_n  = S_FETCH;
      end
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      wb_q  <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      state <= state_n;
      if (pc_ld) pc <= pc_n;
      if (ir_ld) ir <= imem_rdata;
      if (wb_ld) wb_q <= wb_n;
      if (rf_we && rd[RIW-1:0] != '0) rf[rd[RIW-1:0]] <= wb_q;
    end
  end

  // Requests are gated by reset so an in-flight access drops in the reset cycle.
  assign imem_req   = (state == S_FETCH) && !reset;
  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM) && !reset;
  assign dmem_we    = dmem_req && is_sw;
  assign dmem_addr  = rs1_val + (is_sw ? imm_s : imm_i);
  assign dmem_wdata = rs2_val;
  assign retire     = retire_c && !reset;
  assign halt       = (state == S_TRAP);
  assign pc_out     = pc;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: wait-configurable memories, an event monitor, and a store scoreboard per program.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halt;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;

  logic        reset2 = 1'b1;
  logic        imem_req2, imem_ack2, dmem_req2, dmem_we2, dmem_ack2, retire2, halt2;
  logic [31:0] imem_addr2, imem_rdata2, dmem_addr2, dmem_wdata2, dmem_rdata2, pc_out2;

  always #5 clk = ~clk;

  multicycle_core u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .retire(retire), .halt(halt), .pc_out(pc_out)
  );

  multicycle_core #(.XLEN(32), .NREG(16), .RESET_PC(32'h0)) u_dut_e (
    .clk(clk), .reset(reset2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .imem_ack(imem_ack2),
    .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
    .dmem_rdata(dmem_rdata2), .dmem_ack(dmem_ack2),
    .retire(retire2), .halt(halt2), .pc_out(pc_out2)
  );

  assign imem_ack2   = imem_req2;
  assign dmem_ack2   = 1'b0;
  assign dmem_rdata2 = 32'h0;

  // Memory models: ack after a programmable number of wait cycles, or a manual ack override.
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  int          iwait = 0, dwait = 0, icnt = 0, dcnt = 0, cyc = 0;
  logic        man_mode = 1'b0, man_iack = 1'b0;

  assign imem_ack   = man_mode ? man_iack : (imem_req && icnt >= iwait);
  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_ack   = dmem_req && dcnt >= dwait;
  assign dmem_rdata = (dmem_addr[7:0] == 8'h40) ? 32'h7FFF_FFFF : dmem[dmem_addr[7:2]];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:2]] = dmem_wdata;
  end

  // Monitor: records observed events only; tests compare against their own expectations.
  int          ret_q[$], fcyc_q[$];
  logic [31:0] fetch_q[$], ld_q[$];
  logic [63:0] st_q[$], exp_st_q[$];
  int          hs_err = 0, trap_req = 0;
  logic        pi_pend = 1'b0, pd_pend = 1'b0, pi_ack = 1'b0, pd_ack = 1'b0, pd_we = 1'b0;
  logic [31:0] pi_addr = '0, pd_addr = '0, pd_wd = '0;

  always @(negedge clk) begin
    if (reset) begin
      pi_pend = 1'b0; pd_pend = 1'b0; pi_ack = 1'b0; pd_ack = 1'b0;
    end else begin
      if (retire) ret_q.push_back(cyc);
      if (imem_req && imem_ack) begin fetch_q.push_back(imem_addr); fcyc_q.push_back(cyc); end
      if (dmem_req && dmem_ack && dmem_we) st_q.push_back({dmem_addr, dmem_wdata});
      if (dmem_req && dmem_ack && !dmem_we) ld_q.push_back(dmem_addr);
      if (pi_pend && (!imem_req || imem_addr !== pi_addr)) hs_err++;
      if (pd_pend && (!dmem_req || dmem_addr !== pd_addr || dmem_we !== pd_we || dmem_wdata !== pd_wd)) hs_err++;
      if ((pi_ack && imem_req) || (pd_ack && dmem_req)) hs_err++;
      if (halt && (imem_req || dmem_req)) trap_req++;
      pi_pend = imem_req && !imem_ack; pi_addr = imem_addr; pi_ack = imem_req && imem_ack;
      pd_pend = dmem_req && !dmem_ack; pd_addr = dmem_addr; pd_we = dmem_we; pd_wd = dmem_wdata;
      pd_ack  = dmem_req && dmem_ack;
    end
  end

  int checks = 0, passes = 0, pidx = 0;
  int rb, fb, sb, lb, hb, tb0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
  endfunction

  task automatic start_prog(input int iw, input int dw);
    @(negedge clk);
    reset = 1'b1;
    iwait = iw;
    dwait = dw;
    for (int k = 0; k < 64; k++) imem[k] = 32'h0;
    pidx = 0;
  endtask
  task automatic emit(input logic [31:0] w);
    imem[pidx] = w;
    pidx++;
  endtask
  task automatic emit_sw(input int rs2, input int imm, input logic [31:0] exp_data);
    logic [11:0] im;
    im = 12'(imm);
    emit({im[11:5], 5'(rs2), 5'd0, 3'b010, im[4:0], 7'b0100011});
    exp_st_q.push_back({32'(imm), exp_data});
  endtask
  task automatic release_reset();
    repeat (2) @(negedge clk);
    rb = ret_q.size(); fb = fetch_q.size(); sb = st_q.size(); lb = ld_q.size();
    hb = hs_err; tb0 = trap_req;
    reset = 1'b0;
  endtask

  // Waits for every queued store, then pops the scoreboard against the observed stores.
  task automatic drain_stores(input string name);
    int n;
    n = exp_st_q.size();
    for (int t = 0; t < 600 && st_q.size() < sb + n; t++) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      logic [63:0] e;
      e = exp_st_q.pop_front();
      checks++;
      if (st_q.size() <= sb + k)
        $display("FAIL %s store%0d: missing, required addr=%h data=%h", name, k, e[63:32], e[31:0]);
      else if (st_q[sb + k] !== e)
        $display("FAIL %s store%0d: got addr=%h data=%h, required addr=%h data=%h", name, k,
                 st_q[sb + k][63:32], st_q[sb + k][31:0], e[63:32], e[31:0]);
      else passes++;
    end
  endtask

  task automatic test_reset();
    iwait = 15;
    repeat (2) @(negedge clk);
    checks++; if ({imem_req, dmem_req, dmem_we, retire} !== 4'b0) $display("FAIL reset_outputs: got %b required 0000", {imem_req, dmem_req, dmem_we, retire}); else passes++;
    checks++; if (halt !== 1'b0) $display("FAIL reset_halt: got %b required 0", halt); else passes++;
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) $display("FAIL reset_fetch_req: got %b required 1", imem_req); else passes++;
    checks++; if (pc_out !== 32'h0 || imem_addr !== 32'h0) $display("FAIL reset_pc: got pc=%h addr=%h required 0", pc_out, imem_addr); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL fetch_wait_hold: got req=%b addr=%h required 1/0", imem_req, imem_addr); else passes++;
  endtask

  task automatic test_alu();
    start_prog(0, 0);
    emit(enc_i(5, 0, 3'b000, 1, 7'b0010011));
    emit(enc_i(-3, 0, 3'b000, 2, 7'b0010011));
    emit(enc_r(7'h00, 2, 1, 3'b000, 3));
    emit(enc_r(7'h00, 1, 2, 3'b010, 5));
    emit(enc_r(7'h00, 2, 1, 3'b010, 13));
    emit(enc_r(7'h20, 2, 1, 3'b000, 10));
    emit(enc_r(7'h00, 2, 1, 3'b111, 11));
    emit(enc_r(7'h00, 2, 1, 3'b110, 12));
    emit_sw(3, 0, 32'd2);
    emit_sw(5, 4, 32'd1);
    emit_sw(13, 28, 32'd0);
    emit_sw(10, 16, 32'd8);
    emit_sw(11, 20, 32'd5);
    emit_sw(12, 24, 32'hFFFF_FFFD);
    emit(enc_b(0, 0, 0, 3'b000));
    release_reset();
    drain_stores("alu");
    checks++; if (ret_q.size() < rb + 10 || ret_q[rb+1] - ret_q[rb] !== 4) $display("FAIL alu_addi_latency: got %0d required 4", ret_q.size() > rb + 1 ? ret_q[rb+1] - ret_q[rb] : -1); else passes++;
    checks++; if (ret_q.size() < rb + 10 || ret_q[rb+2] - ret_q[rb+1] !== 4) $display("FAIL alu_add_latency: got %0d required 4", ret_q.size() > rb + 2 ? ret_q[rb+2] - ret_q[rb+1] : -1); else passes++;
    checks++; if (ret_q.size() < rb + 10 || ret_q[rb+9] - ret_q[rb+8] !== 4) $display("FAIL store_latency: got %0d required 4", ret_q.size() > rb + 9 ? ret_q[rb+9] - ret_q[rb+8] : -1); else passes++;
  endtask

  task automatic test_load_store_wait();
    start_prog(0, 3);
    emit(enc_i(5, 0, 3'b000, 1, 7'b0010011));
    emit_sw(1, 8, 32'd5);
    emit(enc_i(8, 0, 3'b010, 4, 7'b0000011));
    emit_sw(4, 12, 32'd5);
    emit(enc_b(0, 0, 0, 3'b000));
    release_reset();
    drain_stores("ldst");
    checks++; if (ld_q.size() <= lb || ld_q[lb] !== 32'd8) $display("FAIL load_addr: got %h required 00000008", ld_q.size() > lb ? ld_q[lb] : 32'hx); else passes++;
    checks++; if (ret_q.size() < rb + 3 || ret_q[rb+1] - ret_q[rb] !== 7) $display("FAIL store_wait_latency: got %0d required 7", ret_q.size() > rb + 1 ? ret_q[rb+1] - ret_q[rb] : -1); else passes++;
    checks++; if (ret_q.size() < rb + 3 || ret_q[rb+2] - ret_q[rb+1] !== 8) $display("FAIL load_wait_latency: got %0d required 8", ret_q.size() > rb + 2 ? ret_q[rb+2] - ret_q[rb+1] : -1); else passes++;
    checks++; if (hs_err !== hb) $display("FAIL req_stability: got %0d violations required 0", hs_err - hb); else passes++;
  endtask

  task automatic test_branch();
    logic [31:0] exp_pc [5];
    exp_pc = '{32'h00, 32'h10, 32'h08, 32'h0C, 32'h0C};
    start_prog(0, 0);
    imem[0] = enc_b(16, 0, 0, 3'b000);
    imem[2] = enc_b(64, 0, 0, 3'b001);
    imem[3] = enc_b(0, 0, 0, 3'b000);
    imem[4] = enc_b(-8, 0, 0, 3'b000);
    release_reset();
    for (int t = 0; t < 100 && fetch_q.size() < fb + 5; t++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (fetch_q.size() <= fb + k) $display("FAIL branch_fetch%0d: missing, required %h", k, exp_pc[k]);
      else if (fetch_q[fb + k] !== exp_pc[k]) $display("FAIL branch_fetch%0d: got %h required %h", k, fetch_q[fb + k], exp_pc[k]);
      else passes++;
    end
    checks++; if (fcyc_q.size() < fb + 2 || fcyc_q[fb+1] - fcyc_q[fb] !== 3) $display("FAIL branch_latency: got %0d required 3", fcyc_q.size() > fb + 1 ? fcyc_q[fb+1] - fcyc_q[fb] : -1); else passes++;
  endtask

  task automatic test_overflow_fetch_wait();
    start_prog(2, 0);
    emit(enc_i(64, 0, 3'b010, 7, 7'b0000011));
    emit(enc_i(1, 0, 3'b000, 8, 7'b0010011));
    emit(enc_r(7'h00, 8, 7, 3'b000, 9));
    emit_sw(9, 32, 32'h8000_0000);
    emit(enc_b(0, 0, 0, 3'b000));
    release_reset();
    drain_stores("ovf");
    checks++; if (ret_q.size() < rb + 3 || ret_q[rb+2] - ret_q[rb+1] !== 6) $display("FAIL alu_fetch_wait_latency: got %0d required 6", ret_q.size() > rb + 2 ? ret_q[rb+2] - ret_q[rb+1] : -1); else passes++;
  endtask

  task automatic test_traps();
    start_prog(0, 0);
    emit(enc_i(1, 0, 3'b000, 1, 7'b0010011));
    emit(32'h0000_007F);
    release_reset();
    repeat (20) @(negedge clk);
    checks++; if (halt !== 1'b1 || pc_out !== 32'h4) $display("FAIL trap_opcode: got halt=%b pc=%h required 1/00000004", halt, pc_out); else passes++;
    checks++; if (ret_q.size() - rb !== 1 || trap_req !== tb0) $display("FAIL trap_quiet: got retires=%0d reqs=%0d required 1/0", ret_q.size() - rb, trap_req - tb0); else passes++;
    repeat (10) @(negedge clk);
    checks++; if (halt !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0) $display("FAIL trap_sticky: got halt=%b ireq=%b dreq=%b required 1/0/0", halt, imem_req, dmem_req); else passes++;

    start_prog(0, 0);
    emit(enc_b(2, 0, 0, 3'b000));
    release_reset();
    checks++; if (halt !== 1'b0) $display("FAIL reset_clears_halt: got %b required 0", halt); else passes++;
    repeat (10) @(negedge clk);
    checks++; if (halt !== 1'b1 || pc_out !== 32'h0 || ret_q.size() !== rb) $display("FAIL trap_misaligned: got halt=%b pc=%h retires=%0d required 1/00000000/0", halt, pc_out, ret_q.size() - rb); else passes++;

    imem_rdata2 = enc_r(7'h00, 2, 1, 3'b000, 15);
    @(negedge clk);
    reset2 = 1'b0;
    begin
      int t;
      for (t = 0; t < 20 && !retire2; t++) @(negedge clk);
      checks++; if (t >= 20 || halt2 !== 1'b0) $display("FAIL e_legal_reg: got retire_seen=%b halt=%b required 1/0", t < 20, halt2); else passes++;
    end
    reset2 = 1'b1;
    imem_rdata2 = enc_r(7'h00, 2, 1, 3'b000, 17);
    repeat (2) @(negedge clk);
    reset2 = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (halt2 !== 1'b1 || imem_req2 !== 1'b0 || dmem_req2 !== 1'b0 || dmem_we2 !== 1'b0) $display("FAIL e_trap_reg: got halt=%b ireq=%b dreq=%b required 1/0/0", halt2, imem_req2, dmem_req2); else passes++;
    checks++; if (pc_out2 !== 32'h0 || imem_addr2 !== 32'h0) $display("FAIL e_trap_pc: got %h required 00000000", pc_out2); else passes++;
  endtask

  task automatic test_reset_mid_fetch();
    start_prog(0, 0);
    man_mode = 1'b1;
    man_iack = 1'b0;
    emit(enc_i(7, 0, 3'b000, 0, 7'b0010011));
    emit_sw(0, 36, 32'd0);
    emit(enc_b(0, 0, 0, 3'b000));
    release_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    man_iack = 1'b1;
    checks++; if (imem_req !== 1'b0 || retire !== 1'b0) $display("FAIL reset_drops_req: got req=%b retire=%b required 0/0", imem_req, retire); else passes++;
    @(negedge clk);
    man_iack = 1'b0;
    man_mode = 1'b0;
    fb = fetch_q.size();
    sb = st_q.size();
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL refetch_after_reset: got req=%b addr=%h required 1/00000000", imem_req, imem_addr); else passes++;
    drain_stores("x0");
    checks++; if (fetch_q.size() <= fb || fetch_q[fb] !== 32'h0) $display("FAIL refetch_addr: got %h required 00000000", fetch_q.size() > fb ? fetch_q[fb] : 32'hx); else passes++;
  endtask

  initial begin
    imem_rdata2 = 32'h0;
    test_reset();
    test_alu();
    test_load_store_wait();
    test_branch();
    test_overflow_fetch_wait();
    test_traps();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
